// File: rtl/checkpoint_monitor.sv
// Checkpoint monitor: watches a probe bus for an ordered sequence of signatures,
// each held for HOLD cycles, with an optional per-step timeout.
module checkpoint_monitor #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    parameter int TW    = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int SW   = $clog2(DEPTH + 1)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] probe,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [SW-1:0]    cfg_len,
    input  logic [TW-1:0]    timeout,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [SW-1:0]    step,
    output logic [TW-1:0]    cycles
);

    localparam int HW = $clog2(HOLD + 1);
    localparam logic [HW-1:0] HOLD_W  = HW'(HOLD);
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
    localparam logic [AW:0]   DEPTH_A = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PASS  = 2'd2,
        FAIL  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sig_table_q [DEPTH];
    logic [WIDTH-1:0]  sig_table_d [DEPTH];
    logic [SW-1:0]     len_q, len_d;
    logic [TW-1:0]     timeout_q, timeout_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [SW-1:0]     step_q, step_d;
    logic [TW-1:0]     cycles_q, cycles_d;
    logic              busy_q, busy_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;

    logic [SW-1:0]     len_clamped;
    logic              match;
    logic              advance;
    logic [TW-1:0]     timer_inc;

    assign len_clamped = (cfg_len > DEPTH_S) ? DEPTH_S : cfg_len;
    assign match       = (probe == sig_table_q[step_q[AW-1:0]]);
    assign advance     = match && ((hold_q + HW'(1)) == HOLD_W);
    assign timer_inc   = timer_q + TW'(1);

    // The table is frozen while a sequence is being checked.
    always_comb begin
        sig_table_d = sig_table_q;
        if (cfg_we && (state_q != ARMED) && ({1'b0, cfg_addr} < DEPTH_A)) begin
            sig_table_d[cfg_addr] = cfg_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        timeout_d = timeout_q;
        hold_d    = hold_q;
        timer_d   = timer_q;
        step_d    = step_q;
        cycles_d  = cycles_q;
        busy_d    = busy_q;
        pass_d    = pass_q;
        fail_d    = fail_q;

        case (state_q)
            ARMED: begin
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + TW'(1);
                end
                // Priority: abort, then step advance, then timeout.
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    hold_d  = '0;
                    timer_d = '0;
                end else if (advance) begin
                    step_d  = step_q + SW'(1);
                    hold_d  = '0;
                    timer_d = '0;
                    if ((step_q + SW'(1)) == len_q) begin
                        state_d = PASS;
                        busy_d  = 1'b0;
                        pass_d  = 1'b1;
                    end
                end else begin
                    hold_d  = match ? (hold_q + HW'(1)) : '0;
                    timer_d = timer_inc;
                    if ((timeout_q != '0) && (timer_inc == timeout_q)) begin
                        state_d = FAIL;
                        busy_d  = 1'b0;
                        fail_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    len_d     = len_clamped;
                    timeout_d = timeout;
                    hold_d    = '0;
                    timer_d   = '0;
                    step_d    = '0;
                    cycles_d  = '0;
                    fail_d    = 1'b0;
                    if (len_clamped == '0) begin
                        state_d = PASS;
                        busy_d  = 1'b0;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ARMED;
                        busy_d  = 1'b1;
                        pass_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        sig_table_q <= sig_table_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            len_q     <= '0;
            timeout_q <= '0;
            hold_q    <= '0;
            timer_q   <= '0;
            step_q    <= '0;
            cycles_q  <= '0;
            busy_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            timer_q   <= timer_d;
            step_q    <= step_d;
            cycles_q  <= cycles_d;
            busy_q    <= busy_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
        end
    end

    assign busy   = busy_q;
    assign pass   = pass_q;
    assign fail   = fail_q;
    assign step   = step_q;
    assign cycles = cycles_q;

endmodule

// File: doc/checkpoint_monitor.md
CHECKPOINT_MONITOR -- requirements
Module: checkpoint_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the probe bus and signature width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, the maximum number of signatures in a sequence; it SHALL be at least 1.
REQ-003 SHALL have parameter HOLD, default 2, the number of consecutive cycles a signature must be present to count as matched; it SHALL be at least 1.
REQ-004 SHALL have parameter TW, default 16, the width of the timeout and cycle counters.
REQ-005 SHALL run on one clock, wb_clk_i, with wb_rst_i as the reset; wb_rst_i is synchronous and active-high.
REQ-006 SHALL have ports, in order:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- probe  in  WIDTH  monitored bus, sampled on every rising edge
- cfg_we  in  1  signature table write strobe
- cfg_addr  in  clog2(DEPTH), minimum 1  table index
- cfg_data  in  WIDTH  signature value
- cfg_len  in  clog2(DEPTH+1)  number of signatures to check
- timeout  in  TW  per-step timeout in cycles; 0 disables the timeout
- start  in  1  arm pulse
- abort  in  1  cancel
- busy  out  1  high while armed
- pass  out  1  sticky pass flag
- fail  out  1  sticky fail flag
- step  out  clog2(DEPTH+1)  index of the signature currently expected
- cycles  out  TW  cycles since arm, saturating

Function
REQ-007 SHALL have four FSM states: IDLE, ARMED, PASS, FAIL.
REQ-008 SHALL write cfg_data into table[cfg_addr] on a cfg_we cycle in IDLE, PASS or FAIL; a write in ARMED SHALL be ignored; a write with cfg_addr >= DEPTH SHALL be ignored.
REQ-009 SHALL latch cfg_len and timeout when start is accepted; a cfg_len greater than DEPTH SHALL be clamped to DEPTH.
REQ-010 SHALL accept start in IDLE, PASS or FAIL; on the next cycle it SHALL clear pass and fail, set step=0 and cycles=0, clear the step timer and the hold counter, and enter ARMED.
REQ-011 SHALL, when start is accepted with latched cfg_len==0, enter PASS on the next cycle with pass=1 and busy never asserted.
REQ-012 SHALL ignore start while in ARMED.
REQ-013 SHALL, in ARMED, increment the hold counter each cycle probe==table[step] and clear it on any mismatch.
REQ-014 SHALL, when the hold counter reaches HOLD, increment step, clear the hold counter and clear the step timer in the same edge.
REQ-015 SHALL enter PASS with pass=1 on the edge at which step would reach cfg_len.
REQ-016 SHALL, in ARMED, increment the step timer each cycle; when timeout!=0 and the step timer equals timeout without a step advance, it SHALL enter FAIL with fail=1 and step frozen.
REQ-017 SHALL give a step advance priority over a timeout occurring on the same cycle.
REQ-018 SHALL, on abort in ARMED, return to IDLE without setting pass or fail; abort SHALL take priority over a match and over a timeout.
REQ-019 SHALL ignore abort in states other than ARMED.
REQ-020 SHALL increment cycles every ARMED cycle, saturating at 2^TW-1, and hold its value outside ARMED.
REQ-021 SHALL assert busy exactly while in ARMED; pass and fail SHALL never be high together.
REQ-022 SHALL drive all outputs from registers only.

Reset
REQ-023 SHALL, while wb_rst_i is high at a rising edge, enter IDLE with busy=0, pass=0, fail=0, step=0, cycles=0, and the hold counter and step timer cleared; this SHALL apply in any state, including mid-sequence.
REQ-024 SHALL leave table contents undefined after reset, so software rewrites the table before start.

Verification
REQ-025 Bench SHALL cover: table {AB60, AB61}, len=2, HOLD=2, timeout=100; probe AB60 for 2 cycles, then AB61 for 2 cycles -> pass=1, step=2, fail=0.
REQ-026 Bench SHALL cover: same configuration with probe stuck at 0000 -> fail=1 after exactly 100 ARMED cycles, step=0.
REQ-027 Bench SHALL cover: probe AB60 for 1 cycle, then 1234, then AB60 for 2 cycles -> the hold counter restarts and step reaches 1 only after the second run.
REQ-028 Bench SHALL cover: the hold completes on the same cycle the timer equals timeout -> step advances and no fail.
REQ-029 Bench SHALL cover: start with len=0 -> pass=1 on the next cycle; abort mid-sequence -> IDLE, pass=0, fail=0.
REQ-030 Bench SHALL cover: wb_rst_i asserted in ARMED at step 1 -> all outputs return to reset values on the next edge; a cfg_we during ARMED leaves the table unchanged.
